// File: rtl/sap_1_microsequencer.sv
// -----------------------------------------------------------------------------
// sap_1_microsequencer
//
// Purpose:
//   Microprogram sequencer for the SAP-1 control unit.
//   - It walks the control-ROM address through the fixed fetch microroutine,
//     which sits at addresses 0..FETCH_LEN-1.
//   - It latches the opcode and presents it one-hot to SAP_1_ROM_mapping.
//   - It loads the returned start address and steps the execute microroutine
//     until the control word flags end-of-routine.
//   - HLT parks the block in HALTED. Sequencing errors park it in FAULT.
//     Only reset leaves either state.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_clr_n       asynchronous active-low reset
//   i_run         start/continue request, sampled in IDLE and at instruction end
//   i_opcode      instruction-register opcode field
//   i_map_addr    execute start address from SAP_1_ROM_mapping (combinational)
//   i_uend        end-of-microroutine bit of the current control word
//   o_map_onehot  registered one-hot opcode to SAP_1_ROM_mapping
//   o_upc         registered control-ROM address
//   o_uvalid      control word at o_upc executes this cycle
//   o_instr_done  one-cycle pulse after an instruction completes
//   o_halted      sticky, HLT executed
//   o_fault       sticky, sequencing error
//   o_state       debug view of the FSM state
//
// Handshake:
//   o_uvalid is a qualifier, not a valid/ready pair. The control word at o_upc
//   is consumed in every cycle where o_uvalid=1. There is no back-pressure.
//   i_uend is only meaningful in those same cycles.
// -----------------------------------------------------------------------------
module sap_1_microsequencer #(
  parameter int unsigned FETCH_LEN  = 3,
  parameter int unsigned MAX_STEPS  = 16,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        i_clk,
  input  logic        i_clr_n,
  input  logic        i_run,
  input  logic [3:0]  i_opcode,
  input  logic [7:0]  i_map_addr,
  input  logic        i_uend,
  output logic [15:0] o_map_onehot,
  output logic [7:0]  o_upc,
  output logic        o_uvalid,
  output logic        o_instr_done,
  output logic        o_halted,
  output logic        o_fault,
  output logic [2:0]  o_state
);

  localparam int unsigned STEP_W    = (MAX_STEPS > 2) ? $clog2(MAX_STEPS) : 1;
  localparam logic [7:0]  FETCH_END = 8'(FETCH_LEN - 1);
  localparam logic [7:0]  FETCH_SZ  = 8'(FETCH_LEN);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t              r_state;
  logic [7:0]          r_upc;
  logic [15:0]         r_onehot;
  logic [3:0]          r_opcode;
  logic [STEP_W-1:0]   r_step;
  logic                r_instr_done;

  state_t              w_state_nxt;
  logic [7:0]          w_upc_nxt;
  logic [15:0]         w_onehot_nxt;
  logic [3:0]          w_opcode_nxt;
  logic [STEP_W-1:0]   w_step_nxt;
  logic                w_instr_done_nxt;

  // State register
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers that follow the FSM's next-value decisions
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_upc        <= 8'h00;
      r_onehot     <= 16'h0000;
      r_opcode     <= 4'h0;
      r_step       <= '0;
      r_instr_done <= 1'b0;
    end else begin
      r_upc        <= w_upc_nxt;
      r_onehot     <= w_onehot_nxt;
      r_opcode     <= w_opcode_nxt;
      r_step       <= w_step_nxt;
      r_instr_done <= w_instr_done_nxt;
    end
  end

  // Next-state and next-value logic
  always_comb begin
    w_state_nxt      = r_state;
    w_upc_nxt        = r_upc;
    w_onehot_nxt     = r_onehot;
    w_opcode_nxt     = r_opcode;
    w_step_nxt       = r_step;
    w_instr_done_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_upc_nxt = 8'h00;
        if (i_run) begin
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        if (r_upc == FETCH_END) begin
          // Upc stays on the last fetch word through DECODE.
          w_state_nxt  = S_DECODE;
          w_opcode_nxt = i_opcode;
          w_onehot_nxt = 16'h0001 << i_opcode;
        end else begin
          w_upc_nxt = r_upc + 8'h01;
        end
      end

      S_DECODE: begin
        // HLT wins over a bad mapping. A start address inside the fetch
        // region can only come from a broken mapping ROM.
        if (r_opcode == HLT_OPCODE) begin
          w_state_nxt = S_HALTED;
        end else if (i_map_addr < FETCH_SZ) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_state_nxt = S_EXEC;
          w_upc_nxt   = i_map_addr;
          w_step_nxt  = '0;
        end
      end

      S_EXEC: begin
        if (i_uend) begin
          w_instr_done_nxt = 1'b1;
          w_upc_nxt        = 8'h00;
          w_state_nxt      = i_run ? S_FETCH : S_IDLE;
        end else if (r_upc == 8'hFF) begin
          // The address never wraps into the fetch region.
          w_state_nxt = S_FAULT;
        end else if (r_step == STEP_LAST) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_upc_nxt  = r_upc + 8'h01;
          w_step_nxt = r_step + STEP_W'(1);
        end
      end

      S_HALTED, S_FAULT: begin
        // Terminal states. Everything holds until reset.
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_upc_nxt   = 8'h00;
      end
    endcase
  end

  assign o_upc        = r_upc;
  assign o_map_onehot = r_onehot;
  assign o_uvalid     = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign o_instr_done = r_instr_done;
  assign o_halted     = (r_state == S_HALTED);
  assign o_fault      = (r_state == S_FAULT);
  assign o_state      = r_state;

endmodule

// File: tb/tb_sap_1_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_sap_1_microsequencer
//
// Directed bench for sap_1_microsequencer.
// - A table of {opcode, map address, exec length, expected one-hot} records
//   runs back-to-back instructions.
// - Hand-written sequences cover HLT, the watchdog, bad mapping, the Upc=FF
//   limit, Run dropped mid-instruction and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_sap_1_microsequencer;

  localparam int FETCH_LEN = 3;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  logic        clk;
  logic        clr_n;
  logic        run;
  logic [3:0]  opcode;
  logic [7:0]  map_addr;
  logic        uend;
  logic [15:0] map_onehot;
  logic [7:0]  upc;
  logic        uvalid;
  logic        instr_done;
  logic        halted;
  logic        fault;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  sap_1_microsequencer #(
    .FETCH_LEN (3),
    .MAX_STEPS (16),
    .HLT_OPCODE(4'hF)
  ) dut (
    .i_clk       (clk),
    .i_clr_n     (clr_n),
    .i_run       (run),
    .i_opcode    (opcode),
    .i_map_addr  (map_addr),
    .i_uend      (uend),
    .o_map_onehot(map_onehot),
    .o_upc       (upc),
    .o_uvalid    (uvalid),
    .o_instr_done(instr_done),
    .o_halted    (halted),
    .o_fault     (fault),
    .o_state     (state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: one expected value per comparison, popped as it is checked
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act);
    logic [31:0] exp_v;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (act === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    exp_q.push_back(exp_v);
    chk(name, act);
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, "_upc"},    32'(upc), 32'h00);
    expect_eq({tag, "_onehot"}, 32'(map_onehot), 32'h0000);
    expect_eq({tag, "_uvalid"}, 32'(uvalid), 32'h0);
    expect_eq({tag, "_done"},   32'(instr_done), 32'h0);
    expect_eq({tag, "_halted"}, 32'(halted), 32'h0);
    expect_eq({tag, "_fault"},  32'(fault), 32'h0);
    expect_eq({tag, "_state"},  32'(state), 32'(ST_IDLE));
  endtask

  task automatic do_reset();
    clr_n    = 1'b0;
    run      = 1'b0;
    uend     = 1'b0;
    opcode   = 4'h0;
    map_addr = 8'h00;
    step();
    step();
    clr_n = 1'b1;
    step();
  endtask

  // From IDLE with run=1: one edge into FETCH at Upc=0
  task automatic start_fetch();
    run = 1'b1;
    step();
    expect_eq("fetch_entry_state", 32'(state), 32'(ST_FETCH));
    expect_eq("fetch_entry_upc", 32'(upc), 32'h00);
    expect_eq("fetch_entry_uvalid", 32'(uvalid), 32'h1);
  endtask

  // Called in the first FETCH cycle (Upc=0). Returns in the DECODE cycle.
  task automatic do_fetch(input logic [3:0] op, input logic [15:0] exp_onehot);
    opcode = op;
    for (int k = 1; k < FETCH_LEN; k++) begin
      step();
      expect_eq("fetch_upc", 32'(upc), 32'(k));
    end
    step();
    expect_eq("decode_state", 32'(state), 32'(ST_DECODE));
    expect_eq("decode_upc", 32'(upc), 32'(FETCH_LEN - 1));
    expect_eq("decode_uvalid", 32'(uvalid), 32'h0);
    expect_eq("decode_onehot", 32'(map_onehot), 32'(exp_onehot));
    // The opcode is only captured at the FETCH->DECODE edge.
    opcode = 4'($urandom_range(0, 15));
  endtask

  // Called in the DECODE cycle. Runs n EXEC cycles, with uend on the last one.
  task automatic do_exec(input logic [7:0] maddr, input int n, input logic run_during);
    logic [7:0] a;
    map_addr = maddr;
    step();
    run = run_during;
    for (int i = 0; i < n; i++) begin
      a = maddr + 8'(i);
      expect_eq("exec_upc", 32'(upc), 32'(a));
      expect_eq("exec_uvalid", 32'(uvalid), 32'h1);
      uend = (i == n - 1);
      step();
    end
    uend = 1'b0;
    expect_eq("instr_done_pulse", 32'(instr_done), 32'h1);
    expect_eq("end_upc", 32'(upc), 32'h00);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  maddr;
    int          n;
    logic [15:0] exp_onehot;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int fetch_start;

    vecs[0]  = '{4'h0, 8'h20, 1, 16'h0001};
    vecs[1]  = '{4'h1, 8'h20, 1, 16'h0002};
    vecs[2]  = '{4'h2, 8'h20, 1, 16'h0004};
    vecs[3]  = '{4'h3, 8'h20, 1, 16'h0008};
    vecs[4]  = '{4'h4, 8'h20, 1, 16'h0010};
    vecs[5]  = '{4'h5, 8'h20, 1, 16'h0020};
    vecs[6]  = '{4'h6, 8'h20, 1, 16'h0040};
    vecs[7]  = '{4'h7, 8'h20, 1, 16'h0080};
    vecs[8]  = '{4'h8, 8'h20, 1, 16'h0100};
    vecs[9]  = '{4'h9, 8'h20, 1, 16'h0200};
    vecs[10] = '{4'hA, 8'h20, 1, 16'h0400};
    vecs[11] = '{4'hB, 8'h20, 1, 16'h0800};
    vecs[12] = '{4'hC, 8'h20, 1, 16'h1000};
    vecs[13] = '{4'hD, 8'h20, 1, 16'h2000};
    vecs[14] = '{4'hE, 8'h20, 1, 16'h4000};
    vecs[15] = '{4'h9, 8'h03, 2, 16'h0200};  // lowest legal start address
    vecs[16] = '{4'hC, 8'hF0, 4, 16'h1000};

    // ---- Reset values ----
    do_reset();
    check_reset_outputs("reset");

    // ---- First instruction: Upc 0,1,2,2,10,11,12 then 0 ----
    start_fetch();
    fetch_start = cyc;
    do_fetch(4'h0, 16'h0001);
    do_exec(8'h10, 3, 1'b1);
    expect_eq("first_done_latency", 32'(cyc - fetch_start), 32'd7);
    expect_eq("first_next_state", 32'(state), 32'(ST_FETCH));

    // ---- Table-driven back-to-back instructions ----
    for (int v = 0; v < 17; v++) begin
      do_fetch(vecs[v].op, vecs[v].exp_onehot);
      do_exec(vecs[v].maddr, vecs[v].n, 1'b1);
      expect_eq("vec_next_state", 32'(state), 32'(ST_FETCH));
      expect_eq("vec_onehot_hold", 32'(map_onehot), 32'(vecs[v].exp_onehot));
    end

    // ---- Run dropped during EXEC: finishes, then IDLE ----
    do_fetch(4'h5, 16'h0020);
    do_exec(8'h30, 2, 1'b0);
    expect_eq("rundrop_state", 32'(state), 32'(ST_IDLE));
    expect_eq("rundrop_uvalid", 32'(uvalid), 32'h0);
    step();
    expect_eq("rundrop_idle_stay", 32'(state), 32'(ST_IDLE));
    expect_eq("rundrop_done_single", 32'(instr_done), 32'h0);
    expect_eq("rundrop_idle_upc", 32'(upc), 32'h00);

    // ---- HLT ----
    start_fetch();
    do_fetch(4'hF, 16'h8000);
    map_addr = 8'h40;
    step();
    expect_eq("hlt_halted", 32'(halted), 32'h1);
    expect_eq("hlt_state", 32'(state), 32'(ST_HALTED));
    expect_eq("hlt_uvalid", 32'(uvalid), 32'h0);
    expect_eq("hlt_upc", 32'(upc), 32'h02);
    for (int t = 0; t < 4; t++) begin
      run  = t[0];
      uend = 1'b1;
      step();
      expect_eq("hlt_sticky", 32'(halted), 32'h1);
      expect_eq("hlt_upc_hold", 32'(upc), 32'h02);
    end
    expect_eq("hlt_onehot_hold", 32'(map_onehot), 32'h8000);
    uend = 1'b0;
    do_reset();
    check_reset_outputs("hlt_clr");

    // ---- Watchdog: Uend held 0 from 0x10 -> fault with Upc=0x1F ----
    start_fetch();
    do_fetch(4'h1, 16'h0002);
    map_addr = 8'h10;
    step();
    for (int i = 0; i < 16; i++) begin
      expect_eq("wd_no_fault_yet", 32'(fault), 32'h0);
      step();
    end
    expect_eq("wd_fault", 32'(fault), 32'h1);
    expect_eq("wd_upc", 32'(upc), 32'h1F);
    expect_eq("wd_uvalid", 32'(uvalid), 32'h0);
    run = 1'b0;
    step();
    run = 1'b1;
    step();
    expect_eq("wd_sticky", 32'(state), 32'(ST_FAULT));
    expect_eq("wd_upc_hold", 32'(upc), 32'h1F);

    // ---- Mapping into the fetch region -> fault at DECODE exit ----
    do_reset();
    start_fetch();
    do_fetch(4'h2, 16'h0004);
    map_addr = 8'h01;
    step();
    expect_eq("badmap_fault", 32'(fault), 32'h1);
    expect_eq("badmap_upc", 32'(upc), 32'h02);
    expect_eq("badmap_uvalid", 32'(uvalid), 32'h0);

    // ---- Upc reaches 0xFF without Uend -> fault, no wrap ----
    do_reset();
    start_fetch();
    do_fetch(4'h6, 16'h0040);
    map_addr = 8'hFC;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
    end
    expect_eq("ff_fault", 32'(fault), 32'h1);
    expect_eq("ff_upc", 32'(upc), 32'hFF);

    // ---- Asynchronous reset mid-EXEC ----
    do_reset();
    start_fetch();
    do_fetch(4'h3, 16'h0008);
    map_addr = 8'h40;
    step();
    step();
    expect_eq("async_pre_upc", 32'(upc), 32'h41);
    #2;
    clr_n = 1'b0;
    #1;
    expect_eq("async_upc", 32'(upc), 32'h00);
    expect_eq("async_uvalid", 32'(uvalid), 32'h0);
    expect_eq("async_onehot", 32'(map_onehot), 32'h0000);
    expect_eq("async_state", 32'(state), 32'(ST_IDLE));
    run = 1'b0;
    step();
    clr_n = 1'b1;
    step();
    expect_eq("async_release_idle", 32'(state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
